// File: rtl/display_scan_manager.sv
// Single-clock multiplexed display scanner: snapshots a packed digit bank and walks it onto
// active-low anodes, with a blank gap between digits. Optional blink feature: DISPLAY_SCAN_BLINK_EN.
module display_scan_manager #(
    parameter int NUM_DIGITS = 8,
    parameter int DIGIT_W    = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 16
`ifdef DISPLAY_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 50
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          update_i,
    input  logic                          freeze_i,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]         blank_mask_i,
`ifdef DISPLAY_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]         blink_mask_i,
`endif
    output logic [NUM_DIGITS-1:0]         an_o,
    output logic [DIGIT_W-1:0]            digit_o,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o,
    output logic                          scan_tick_o,
    output logic                          valid_o
);

    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_e;

    state_e                        state_q, state_d;
    logic [IW-1:0]                 idx_q, idx_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [NUM_DIGITS*DIGIT_W-1:0] snap_q, snap_d;
    logic                          valid_q, valid_d;
    logic [NUM_DIGITS-1:0]         an_q, an_d;
    logic [DIGIT_W-1:0]            digit_q, digit_d;
    logic                          tick_q, tick_d;
    logic                          load;
    logic                          leave_off;
    logic [IW-1:0]                 idx_next;

`ifdef DISPLAY_SCAN_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] frame_q, frame_d;
    logic          phase_q, phase_d;
`endif

    // State register: every output is a flop loaded from its next-state value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_OFF;
            idx_q   <= '0;
            cnt_q   <= '0;
            snap_q  <= '0;
            valid_q <= 1'b0;
            an_q    <= '1;
            digit_q <= '0;
            tick_q  <= 1'b0;
`ifdef DISPLAY_SCAN_BLINK_EN
            frame_q <= '0;
            phase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            valid_q <= valid_d;
            an_q    <= an_d;
            digit_q <= digit_d;
            tick_q  <= tick_d;
`ifdef DISPLAY_SCAN_BLINK_EN
            frame_q <= frame_d;
            phase_q <= phase_d;
`endif
        end
    end

    assign idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

    // Next-state logic: snapshot loads never disturb the scan position.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        tick_d    = 1'b0;
        leave_off = 1'b0;
        load      = update_i && !freeze_i;
        snap_d    = load ? digits_i : snap_q;
        valid_d   = valid_q | load;

        case (state_q)
            S_OFF: begin
                if (load) begin
                    leave_off = 1'b1;
                    idx_d     = '0;
                    cnt_d     = '0;
                    state_d   = (BLANK_CYC == 0) ? S_SHOW : S_BLANK;
                end
            end
            S_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SHOW;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d   = '0;
                    idx_d   = idx_next;
                    state_d = (BLANK_CYC == 0) ? S_SHOW : S_BLANK;
                    tick_d  = (idx_q == IDX_LAST);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_OFF;
        endcase
    end

`ifdef DISPLAY_SCAN_BLINK_EN
    always_comb begin
        frame_d = frame_q;
        phase_d = phase_q;
        if (leave_off) begin
            frame_d = '0;
            phase_d = 1'b0;
        end else if (tick_d) begin
            if (frame_q == FRAME_LAST) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end
    end
`endif

    // Output logic, decoded from the next state so anodes switch with idx.
    always_comb begin
        an_d    = '1;
        digit_d = '0;
        if (state_d == S_SHOW) begin
            an_d = ~(NUM_DIGITS'(1) << idx_d) | blank_mask_i;
`ifdef DISPLAY_SCAN_BLINK_EN
            if (phase_d) begin
                an_d = an_d | blink_mask_i;
            end
`endif
            digit_d = snap_d[idx_d*DIGIT_W +: DIGIT_W];
        end
    end

    assign an_o        = an_q;
    assign digit_o     = digit_q;
    assign digit_idx_o = idx_q;
    assign scan_tick_o = tick_q;
    assign valid_o     = valid_q;

endmodule

// File: tb/tb_display_scan_manager.sv
// Directed bench for display_scan_manager with 4 digits, SCAN_DIV=4, BLANK_CYC=1.
module tb_display_scan_manager;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        update_i;
    logic        freeze_i;
    logic [15:0] digits_i;
    logic [3:0]  blank_mask_i;
    logic [3:0]  an_o;
    logic [3:0]  digit_o;
    logic [1:0]  digit_idx_o;
    logic        scan_tick_o;
    logic        valid_o;

    int tests = 0;
    int fails = 0;

    display_scan_manager #(
        .NUM_DIGITS(4),
        .DIGIT_W   (4),
        .SCAN_DIV  (4),
        .BLANK_CYC (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .update_i    (update_i),
        .freeze_i    (freeze_i),
        .digits_i    (digits_i),
        .blank_mask_i(blank_mask_i),
        .an_o        (an_o),
        .digit_o     (digit_o),
        .digit_idx_o (digit_idx_o),
        .scan_tick_o (scan_tick_o),
        .valid_o     (valid_o)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs changed and outputs sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts on the blank cycle before digit 0 and ends on the next one.
    task automatic frame_check(input logic [15:0] vals, input logic [3:0] mask);
        logic [3:0] an_exp;
        for (int k = 0; k < 4; k++) begin
            an_exp = ~(4'b0001 << k) | mask;
            for (int c = 0; c < 4; c++) begin
                step();
                chk($sformatf("show_an_d%0d_c%0d", k, c), an_o, an_exp);
                chk($sformatf("show_digit_d%0d_c%0d", k, c), digit_o, vals[k*4 +: 4]);
                chk($sformatf("show_idx_d%0d_c%0d", k, c), digit_idx_o, k);
                chk($sformatf("show_tick_d%0d_c%0d", k, c), scan_tick_o, 1'b0);
            end
            step();
            chk($sformatf("blank_an_after_d%0d", k), an_o, 4'hF);
            chk($sformatf("blank_digit_after_d%0d", k), digit_o, 4'h0);
            chk($sformatf("blank_idx_after_d%0d", k), digit_idx_o, (k + 1) % 4);
            chk($sformatf("blank_tick_after_d%0d", k), scan_tick_o, (k == 3));
        end
    endtask

    initial begin
        int tick_hits;
        int an_bad;
        int n;

        rst_n        = 1'b0;
        update_i     = 1'b0;
        freeze_i     = 1'b0;
        digits_i     = 16'h0;
        blank_mask_i = 4'h0;
        repeat (3) step();
        rst_n = 1'b1;
        chk("rst_an", an_o, 4'hF);
        chk("rst_digit", digit_o, 4'h0);
        chk("rst_idx", digit_idx_o, 2'd0);
        chk("rst_tick", scan_tick_o, 1'b0);
        chk("rst_valid", valid_o, 1'b0);

        // Idle with no update: display stays dark.
        tick_hits = 0;
        an_bad    = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (scan_tick_o) tick_hits++;
            if (an_o !== 4'hF) an_bad++;
        end
        chk("idle_tick_hits", tick_hits, 0);
        chk("idle_an_bad", an_bad, 0);
        chk("idle_digit", digit_o, 4'h0);
        chk("idle_valid", valid_o, 1'b0);

        // First load.
        digits_i = 16'h4321;
        update_i = 1'b1;
        step();
        update_i = 1'b0;
        chk("load_blank_an", an_o, 4'hF);
        chk("load_blank_digit", digit_o, 4'h0);
        chk("load_blank_idx", digit_idx_o, 2'd0);
        chk("load_valid", valid_o, 1'b1);
        frame_check(16'h4321, 4'h0);

        // Frame period between scan ticks.
        n = 0;
        do begin
            step();
            n++;
        end while (!scan_tick_o && n <= 40);
        chk("tick_period", n, 20);

        // Frozen: updates ignored for a whole frame.
        freeze_i = 1'b1;
        update_i = 1'b1;
        digits_i = 16'hFFFF;
        frame_check(16'h4321, 4'h0);
        update_i = 1'b0;
        freeze_i = 1'b0;
        digits_i = 16'h4321;
        chk("freeze_valid", valid_o, 1'b1);

        // Blank mask on digit 2.
        blank_mask_i = 4'b0100;
        frame_check(16'h4321, 4'b0100);
        blank_mask_i = 4'h0;

        // Update mid-digit 1: value changes at once, timing unchanged.
        repeat (5) step();
        step();
        chk("mid_d1_c0_digit", digit_o, 4'h2);
        step();
        chk("mid_d1_c1_digit", digit_o, 4'h2);
        digits_i = 16'h8765;
        update_i = 1'b1;
        step();
        update_i = 1'b0;
        chk("mid_d1_c2_digit", digit_o, 4'h6);
        chk("mid_d1_c2_an", an_o, 4'b1101);
        step();
        chk("mid_d1_c3_digit", digit_o, 4'h6);
        chk("mid_d1_c3_idx", digit_idx_o, 2'd1);
        step();
        chk("mid_blank_an", an_o, 4'hF);
        chk("mid_blank_idx", digit_idx_o, 2'd2);
        step();
        chk("mid_d2_digit", digit_o, 4'h7);
        chk("mid_d2_an", an_o, 4'b1011);

        // Reset in the middle of digit 2.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_an", an_o, 4'hF);
        chk("midrst_valid", valid_o, 1'b0);
        chk("midrst_digit", digit_o, 4'h0);
        chk("midrst_idx", digit_idx_o, 2'd0);
        an_bad = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (an_o !== 4'hF) an_bad++;
        end
        chk("midrst_dark", an_bad, 0);

        // New load restarts from digit 0 with the new snapshot.
        digits_i = 16'h8765;
        update_i = 1'b1;
        step();
        update_i = 1'b0;
        chk("reload_valid", valid_o, 1'b1);
        chk("reload_blank_an", an_o, 4'hF);
        frame_check(16'h8765, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
